// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port (fetch/data) arbiter onto one single-cycle SRAM
module sram_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        sram_en,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    // Saturation point of the data-grant streak; the counter is 3 bits wide.
    localparam logic [2:0] STREAK_LIM = 3'(STARVE_MAX);

    state_t      state_q, state_d;
    logic [2:0]  streak_q, streak_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        grant_i, grant_d;

    // Grant selection, next-state, streak update and all port outputs.
    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = inst_rdata_q;
        data_rdata   = data_rdata_q;

        case (state_q)
            IDLE: begin
                // Grants are gated by resetn so nothing leaks out while reset is held.
                if (resetn && data_req && (!inst_req || (streak_q < STREAK_LIM))) begin
                    grant_d = 1'b1;
                end else if (resetn && inst_req) begin
                    grant_i = 1'b1;
                end

                if (grant_d) begin
                    state_d = WAIT_D;
                    if (!inst_req) begin
                        streak_d = 3'd0;
                    end else if (streak_q < STREAK_LIM) begin
                        streak_d = streak_q + 3'd1;
                    end else begin
                        streak_d = STREAK_LIM;
                    end
                end else if (grant_i) begin
                    state_d  = WAIT_I;
                    streak_d = 3'd0;
                end
            end
            WAIT_I: begin
                inst_data_ok = 1'b1;
                inst_rdata   = sram_rdata;
                inst_rdata_d = sram_rdata;
                state_d      = IDLE;
            end
            WAIT_D: begin
                data_data_ok = 1'b1;
                data_rdata   = sram_rdata;
                data_rdata_d = sram_rdata;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        inst_addr_ok = grant_i;
        data_addr_ok = grant_d;
        sram_en      = grant_i | grant_d;
        sram_we      = grant_d & data_we;
        sram_addr    = grant_d ? data_addr : (grant_i ? inst_addr : 32'd0);
        sram_wdata   = grant_d ? data_wdata : 32'd0;
    end

    // State, streak and held read data registers; reset abandons any access.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            streak_q     <= 3'd0;
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
module tb_sram_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        mem_init;

    int checks;
    int errors;

    typedef struct {
        logic        is_inst;
        logic        is_store;
        logic [31:0] addr;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic        grant_log[$];
    logic [31:0] ref_mem [256];
    logic        ref_written [256];

    logic [31:0] sram_mem [256];
    logic [255:0] sram_written;

    sram_arbiter #(.STARVE_MAX(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_we      (data_we),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5EED_0000;
    endfunction

    // SRAM model: synchronous write, read data valid the cycle after an enabled read.
    always @(posedge clk) begin
        if (mem_init) begin
            sram_written <= '0;
        end else if (sram_en) begin
            if (sram_we) begin
                sram_mem[sram_addr[9:2]]     <= sram_wdata;
                sram_written[sram_addr[9:2]] <= 1'b1;
            end else begin
                sram_rdata <= sram_written[sram_addr[9:2]] ? sram_mem[sram_addr[9:2]] : init_word(sram_addr);
            end
        end
    end

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_written[a[9:2]] ? ref_mem[a[9:2]] : init_word(a);
    endfunction

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    // Protocol monitor and scoreboard, sampled on the falling edge.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                checks++;
                if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we} !== 6'b0 ||
                    sram_addr !== 32'd0 || sram_wdata !== 32'd0 || inst_rdata !== 32'd0 || data_rdata !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_outputs: ok/en/we=%b addr=%h wdata=%h irdata=%h drdata=%h, required all 0",
                             {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we},
                             sram_addr, sram_wdata, inst_rdata, data_rdata);
                end
                exp_q.delete();
            end else begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (inst_data_ok !== e.is_inst || data_data_ok !== !e.is_inst) begin
                        errors++;
                        $display("FAIL data_ok_match: inst_data_ok=%b data_data_ok=%b, required inst=%b data=%b",
                                 inst_data_ok, data_data_ok, e.is_inst, !e.is_inst);
                    end
                    if (!e.is_store) begin
                        checks++;
                        if ((e.is_inst ? inst_rdata : data_rdata) !== e.rdata) begin
                            errors++;
                            $display("FAIL read_data addr=%h: got %h, required %h", e.addr,
                                     e.is_inst ? inst_rdata : data_rdata, e.rdata);
                        end
                    end
                    checks++;
                    if (inst_addr_ok || data_addr_ok || sram_en) begin
                        errors++;
                        $display("FAIL grant_in_wait: inst_addr_ok=%b data_addr_ok=%b sram_en=%b, required 0",
                                 inst_addr_ok, data_addr_ok, sram_en);
                    end
                end else begin
                    checks++;
                    if (inst_data_ok || data_data_ok) begin
                        errors++;
                        $display("FAIL spurious_data_ok: inst=%b data=%b, required 0", inst_data_ok, data_data_ok);
                    end
                end

                checks++;
                if (inst_addr_ok && data_addr_ok) begin
                    errors++;
                    $display("FAIL both_addr_ok: inst=1 data=1, required at most one");
                end

                if (data_addr_ok) begin
                    checks++;
                    if (sram_en !== 1'b1 || sram_we !== data_we || sram_addr !== data_addr ||
                        sram_wdata !== data_wdata) begin
                        errors++;
                        $display("FAIL data_grant_bus: en=%b we=%b addr=%h wdata=%h, required 1 %b %h %h",
                                 sram_en, sram_we, sram_addr, sram_wdata, data_we, data_addr, data_wdata);
                    end
                    e.is_inst  = 1'b0;
                    e.is_store = data_we;
                    e.addr     = data_addr;
                    e.rdata    = ref_read(data_addr);
                    if (data_we) begin
                        ref_mem[data_addr[9:2]]     = data_wdata;
                        ref_written[data_addr[9:2]] = 1'b1;
                    end
                    exp_q.push_back(e);
                    grant_log.push_back(1'b0);
                end else if (inst_addr_ok) begin
                    checks++;
                    if (sram_en !== 1'b1 || sram_we !== 1'b0 || sram_addr !== inst_addr || sram_wdata !== 32'd0) begin
                        errors++;
                        $display("FAIL inst_grant_bus: en=%b we=%b addr=%h wdata=%h, required 1 0 %h 0",
                                 sram_en, sram_we, sram_addr, sram_wdata, inst_addr);
                    end
                    e.is_inst  = 1'b1;
                    e.is_store = 1'b0;
                    e.addr     = inst_addr;
                    e.rdata    = ref_read(inst_addr);
                    exp_q.push_back(e);
                    grant_log.push_back(1'b1);
                end else begin
                    checks++;
                    if (sram_en !== 1'b0 || sram_we !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_bus: en=%b we=%b, required 0 0", sram_en, sram_we);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        mem_init   = 1'b1;
        inst_req   = 1'b1;
        inst_addr  = 32'h0000_0040;
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 32'h0000_0044;
        data_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 256; i++) ref_written[i] = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0 || sram_en !== 1'b0 || sram_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_gates_grant: iok=%b dok=%b en=%b addr=%h, required 0", inst_addr_ok,
                     data_addr_ok, sram_en, sram_addr);
        end
        drive_edge();
        inst_req = 1'b0;
        data_req = 1'b0;
        data_we  = 1'b0;
        drive_edge();
        mem_init = 1'b0;
        resetn   = 1'b1;
        drive_edge();
    endtask

    task automatic test_single_fetch();
        logic [31:0] exp_word;
        exp_word  = init_word(32'h1C00_0000);
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0000;
        @(negedge clk);
        checks++;
        if (inst_addr_ok !== 1'b1 || sram_en !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 32'h1C00_0000) begin
            errors++;
            $display("FAIL fetch_grant: iok=%b en=%b we=%b addr=%h, required 1 1 0 1c000000",
                     inst_addr_ok, sram_en, sram_we, sram_addr);
        end
        drive_edge();
        inst_req = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== exp_word) begin
            errors++;
            $display("FAIL fetch_data: ok=%b rdata=%h, required 1 %h", inst_data_ok, inst_rdata, exp_word);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (inst_rdata !== exp_word) begin
            errors++;
            $display("FAIL fetch_hold: rdata=%h, required %h", inst_rdata, exp_word);
        end
        drive_edge();
    endtask

    task automatic test_store_load();
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 32'h0000_0100;
        data_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (data_addr_ok !== 1'b1 || sram_we !== 1'b1 || sram_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_grant: dok=%b we=%b wdata=%h, required 1 1 deadbeef", data_addr_ok, sram_we, sram_wdata);
        end
        drive_edge();
        data_we    = 1'b0;
        data_wdata = 32'd0;
        @(negedge clk);
        checks++;
        if (data_data_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL store_done: data_ok=%b addr_ok=%b, required 1 0", data_data_ok, data_addr_ok);
        end
        @(negedge clk);
        checks++;
        if (data_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL load_grant_2cyc: addr_ok=%b, required 1", data_addr_ok);
        end
        drive_edge();
        data_req = 1'b0;
        @(negedge clk);
        checks++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_data: ok=%b rdata=%h, required 1 deadbeef", data_data_ok, data_rdata);
        end
        drive_edge();
    endtask

    task automatic test_collision();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0200;
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 32'h0000_0104;
        @(negedge clk);
        checks++;
        if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL collision_first: dok=%b iok=%b, required 1 0", data_addr_ok, inst_addr_ok);
        end
        drive_edge();
        data_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (inst_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL collision_second: iok=%b, required 1", inst_addr_ok);
        end
        drive_edge();
        inst_req = 1'b0;
        drive_edge();
    endtask

    task automatic test_starvation();
        bit done;
        grant_log.delete();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0300;
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 32'h0000_0100;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (grant_log.size() >= 10) begin
                done = 1'b1;
                break;
            end
        end
        drive_edge();
        inst_req = 1'b0;
        data_req = 1'b0;
        repeat (2) drive_edge();
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL starve_timeout: grants=%0d, required 10", grant_log.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (grant_log[k] !== ((k % 5) == 4)) begin
                    errors++;
                    $display("FAIL starve_order[%0d]: inst=%b, required %b", k, grant_log[k], (k % 5) == 4);
                end
            end
        end
    endtask

    task automatic test_withdraw();
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 32'h0000_0108;
        @(negedge clk);
        drive_edge();
        data_req  = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0400;
        @(negedge clk);
        checks++;
        if (inst_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_wait: iok=%b, required 0", inst_addr_ok);
        end
        drive_edge();
        inst_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (inst_addr_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
                errors++;
                $display("FAIL withdraw_ignored: iok=%b idok=%b, required 0 0", inst_addr_ok, inst_data_ok);
            end
        end
        drive_edge();
    endtask

    task automatic test_reset_mid();
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 32'h0000_010C;
        data_wdata = 32'h1234_5678;
        @(negedge clk);
        drive_edge();
        data_req  = 1'b0;
        data_we   = 1'b0;
        resetn    = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0040;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (data_data_ok !== 1'b0 || inst_addr_ok !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet: ddok=%b iok=%b, required 0 0", data_data_ok, inst_addr_ok);
            end
            drive_edge();
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (inst_addr_ok !== 1'b1 || data_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_grant: iok=%b ddok=%b, required 1 0", inst_addr_ok, data_data_ok);
        end
        drive_edge();
        inst_req = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== init_word(32'h1C00_0040)) begin
            errors++;
            $display("FAIL reset_release_data: ok=%b rdata=%h, required 1 %h", inst_data_ok, inst_rdata,
                     init_word(32'h1C00_0040));
        end
        repeat (2) drive_edge();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        resetn     = 1'b0;
        mem_init   = 1'b1;
        inst_req   = 1'b0;
        inst_addr  = 32'd0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_addr  = 32'd0;
        data_wdata = 32'd0;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_single_fetch();
        test_store_load();
        test_collision();
        test_starvation();
        test_withdraw();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
